// File: rtl/snes_seq_pkg.sv
// Shared types and constants for the SNES ROM/SaveRAM sequencer.
//   - default wait constants (read strobe, write strobe, recovery)
//   - FSM state encoding, request kind (RD/WR) and source (SNES/MCU) codes
//   - req_t: one latched memory request (kind, address, write data)
//   - acc_state(): maps a granted request to its access state
package snes_seq_pkg;

    localparam int RD_WAIT_DEF = 5;
    localparam int WR_WAIT_DEF = 4;
    localparam int RECOVER_DEF = 1;

    localparam int AW = 24;
    localparam int DW = 8;
    localparam int CW = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRD  = 3'd1,
        ST_SWR  = 3'd2,
        ST_MRD  = 3'd3,
        ST_MWR  = 3'd4,
        ST_REC  = 3'd5
    } state_e;

    typedef enum logic {
        KIND_RD = 1'b0,
        KIND_WR = 1'b1
    } kind_e;

    typedef enum logic {
        SRC_SNES = 1'b0,
        SRC_MCU  = 1'b1
    } src_e;

    typedef struct packed {
        kind_e         kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    function automatic state_e acc_state(input src_e src, input kind_e kind);
        if (src == SRC_SNES) return (kind == KIND_WR) ? ST_SWR : ST_SRD;
        return (kind == KIND_WR) ? ST_MWR : ST_MRD;
    endfunction

endpackage

// File: rtl/snes_rom_sequencer_if.sv
// Bus bundle of the ROM sequencer: decoded SNES accesses, MCU requests and
// the async SRAM pins.
//   slave  : the sequencer side (consumes requests, drives SRAM and read data)
//   master : the environment side (SNES/decoder, MCU and SRAM data return)
interface snes_rom_sequencer_if;
    import snes_seq_pkg::*;

    logic          SNES_rd_start;
    logic          SNES_wr_end;
    logic [AW-1:0] DEC_ADDR;
    logic          DEC_HIT;
    logic          DEC_WRITABLE;
    logic [DW-1:0] SNES_DIN;
    logic [DW-1:0] SNES_DOUT;
    logic          SNES_rd_done;

    logic          MCU_RRQ;
    logic          MCU_WRQ;
    logic [AW-1:0] MCU_ADDR;
    logic [DW-1:0] MCU_DOUT;
    logic [DW-1:0] MCU_DIN;
    logic          MCU_RDY;

    logic [AW-1:0] ROM_ADDR;
    logic [DW-1:0] ROM_DOUT;
    logic [DW-1:0] ROM_DIN;
    logic          ROM_DOE;
    logic          ROM_CE_N;
    logic          ROM_OE_N;
    logic          ROM_WE_N;

    modport slave (
        input  SNES_rd_start, SNES_wr_end, DEC_ADDR, DEC_HIT, DEC_WRITABLE, SNES_DIN,
        input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, ROM_DIN,
        output SNES_DOUT, SNES_rd_done, MCU_DIN, MCU_RDY,
        output ROM_ADDR, ROM_DOUT, ROM_DOE, ROM_CE_N, ROM_OE_N, ROM_WE_N
    );

    modport master (
        output SNES_rd_start, SNES_wr_end, DEC_ADDR, DEC_HIT, DEC_WRITABLE, SNES_DIN,
        output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, ROM_DIN,
        input  SNES_DOUT, SNES_rd_done, MCU_DIN, MCU_RDY,
        input  ROM_ADDR, ROM_DOUT, ROM_DOE, ROM_CE_N, ROM_OE_N, ROM_WE_N
    );

endinterface

// File: rtl/seq_req_slot.sv
// One-deep request latch.
//   clk_i, rst_ni : clock, async active-low reset
//   set_i         : capture req_i (overwrites a pending request)
//   clr_i         : drop the pending request; wins over set_i, because a
//                   same-cycle set is consumed directly by the arbiter
//   vld_o, req_o  : pending flag and latched request
module seq_req_slot
    import snes_seq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_i,
    input  logic clr_i,
    input  req_t req_i,
    output logic vld_o,
    output req_t req_o
);

    logic vld_q;
    req_t req_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= 1'b0;
            req_q <= '0;
        end else if (clr_i) begin
            vld_q <= 1'b0;
        end else if (set_i) begin
            vld_q <= 1'b1;
            req_q <= req_i;
        end
    end

    assign vld_o = vld_q;
    assign req_o = req_q;

endmodule

// File: rtl/snes_rom_sequencer.sv
// Memory-side responder for decoded SNES cartridge accesses on an 8-bit
// async SRAM, with MCU accesses slotted into idle gaps.
//   CLK, RST_N : clock, async active-low reset
//   bus        : snes_rom_sequencer_if.slave (SNES/decoder, MCU, SRAM pins)
// Parameters: RD_WAIT (OE_N low cycles), WR_WAIT (WE_N low cycles),
// RECOVER (all-strobes-high cycles between accesses).
module snes_rom_sequencer
    import snes_seq_pkg::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF,
    parameter int RECOVER = RECOVER_DEF
) (
    input logic                 CLK,
    input logic                 RST_N,
    snes_rom_sequencer_if.slave bus
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rom_addr_q;
    logic [DW-1:0] rom_dout_q, snes_dout_q, mcu_din_q;
    logic          doe_q, ce_n_q, oe_n_q, we_n_q;
    logic          doe_d, ce_n_d, oe_n_d, we_n_d;
    logic          rd_done_q, mcu_rdy_q;

    // Incoming request qualification; dropped SNES pulses never reach a slot.
    logic s_hit_rd, s_set, m_set;
    req_t s_in, m_in, s_slot, m_slot, s_sel, m_sel, grant;
    logic s_vld, m_vld, s_req, m_req, take_s, take_m;

    assign s_hit_rd = bus.SNES_rd_start & bus.DEC_HIT;
    assign s_set    = s_hit_rd | (bus.SNES_wr_end & bus.DEC_HIT & bus.DEC_WRITABLE);
    assign m_set    = (bus.MCU_RRQ | bus.MCU_WRQ) & mcu_rdy_q;

    always_comb begin
        s_in      = '0;
        s_in.kind = s_hit_rd ? KIND_RD : KIND_WR;
        s_in.addr = bus.DEC_ADDR;
        s_in.data = bus.SNES_DIN;
        m_in      = '0;
        m_in.kind = bus.MCU_RRQ ? KIND_RD : KIND_WR;  // RRQ+WRQ reads
        m_in.addr = bus.MCU_ADDR;
        m_in.data = bus.MCU_DOUT;
    end

    seq_req_slot u_snes_slot (
        .clk_i (CLK), .rst_ni (RST_N), .set_i (s_set), .clr_i (take_s),
        .req_i (s_in), .vld_o (s_vld), .req_o (s_slot)
    );

    seq_req_slot u_mcu_slot (
        .clk_i (CLK), .rst_ni (RST_N), .set_i (m_set), .clr_i (take_m),
        .req_i (m_in), .vld_o (m_vld), .req_o (m_slot)
    );

    // A pulse arriving in the arbitration cycle bypasses its slot, so an
    // idle sequencer starts the access on the very next edge. A fresh SNES
    // pulse also supersedes an older pending one (last wins).
    assign s_req = s_set | s_vld;
    assign m_req = m_set | m_vld;
    assign s_sel = s_set ? s_in : s_slot;
    assign m_sel = m_set ? m_in : m_slot;

    // The first cycle of an access is address/data setup with strobes high;
    // the counter only runs while the strobe is actually asserted.
    logic is_rd, is_wr, rd_act, wr_act, acc_done, arb;
    assign is_rd    = (state_q == ST_SRD) || (state_q == ST_MRD);
    assign is_wr    = (state_q == ST_SWR) || (state_q == ST_MWR);
    assign rd_act   = is_rd && !oe_n_q;
    assign wr_act   = is_wr && !we_n_q;
    assign acc_done = (rd_act || wr_act) && (cnt_q == 4'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arb     = 1'b0;
        take_s  = 1'b0;
        take_m  = 1'b0;
        grant   = '0;
        case (state_q)
            ST_IDLE: arb = 1'b1;
            ST_SRD, ST_MRD, ST_SWR, ST_MWR: begin
                if (acc_done) begin
                    if (RECOVER == 0) begin
                        arb = 1'b1;
                    end else begin
                        state_d = ST_REC;
                        cnt_d   = CW'(RECOVER);
                    end
                end else if (rd_act || wr_act) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REC: begin
                if (cnt_q <= 4'd1) arb = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb) begin
            state_d = ST_IDLE;
            if (s_req) begin
                take_s  = 1'b1;
                grant   = s_sel;
                state_d = acc_state(SRC_SNES, s_sel.kind);
            end else if (m_req) begin
                take_m  = 1'b1;
                grant   = m_sel;
                state_d = acc_state(SRC_MCU, m_sel.kind);
            end
            if (take_s || take_m)
                cnt_d = (grant.kind == KIND_WR) ? CW'(WR_WAIT) : CW'(RD_WAIT);
        end
    end

    // Strobes fall one cycle after entry and rise on the edge the access
    // completes, even when RECOVER=0 chains straight into the next access.
    assign oe_n_d = !(is_rd && !acc_done);
    assign we_n_d = !(is_wr && !acc_done);
    assign ce_n_d = oe_n_d & we_n_d;
    assign doe_d  = (state_d == ST_SWR) || (state_d == ST_MWR);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            rom_dout_q  <= '0;
            doe_q       <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            snes_dout_q <= '0;
            rd_done_q   <= 1'b0;
            mcu_din_q   <= '0;
            mcu_rdy_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            doe_q     <= doe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            rd_done_q <= 1'b0;
            if (take_s || take_m) begin
                rom_addr_q <= grant.addr;
                rom_dout_q <= grant.data;
            end
            if (acc_done && state_q == ST_SRD) begin
                snes_dout_q <= bus.ROM_DIN;
                rd_done_q   <= 1'b1;
            end
            if (acc_done && state_q == ST_MRD) mcu_din_q <= bus.ROM_DIN;
            if (m_set)
                mcu_rdy_q <= 1'b0;
            else if (acc_done && (state_q == ST_MRD || state_q == ST_MWR))
                mcu_rdy_q <= 1'b1;
        end
    end

    assign bus.ROM_ADDR     = rom_addr_q;
    assign bus.ROM_DOUT     = rom_dout_q;
    assign bus.ROM_DOE      = doe_q;
    assign bus.ROM_CE_N     = ce_n_q;
    assign bus.ROM_OE_N     = oe_n_q;
    assign bus.ROM_WE_N     = we_n_q;
    assign bus.SNES_DOUT    = snes_dout_q;
    assign bus.SNES_rd_done = rd_done_q;
    assign bus.MCU_DIN      = mcu_din_q;
    assign bus.MCU_RDY      = mcu_rdy_q;

endmodule
